// File: rtl/soc_pkg.sv
// Shared SoC definitions: RST opcode encoding, default IO ports and source limits.
package soc_pkg;

    localparam logic [7:0] RST_OPCODE_BASE = 8'hC7;
    localparam logic [7:0] SPURIOUS_VEC    = 8'hFF;
    localparam logic [7:0] DEF_MASK_PORT   = 8'h05;
    localparam logic [7:0] DEF_PEND_PORT   = 8'h06;
    localparam int         MAX_INT_SRC     = 8;

    // Acknowledge handshake: idle, or inside an i_inta high window.
    typedef enum logic {
        ACK_IDLE = 1'b0,
        ACK_BUSY = 1'b1
    } ack_state_t;

    // RST n opcode is 11nnn111, i.e. the base opcode with n in bits 5:3.
    function automatic logic [7:0] rst_opcode(input logic [2:0] rstNum);
        return RST_OPCODE_BASE | {2'b00, rstNum, 3'b000};
    endfunction

endpackage

// File: rtl/i8080_int_ctrl_sync_edge.sv
// Per-source synchroniser with a one-cycle rising-edge pulse in the CPU clock domain.
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    // Shift the raw line through the synchroniser, keep one extra flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_last;

endmodule

// File: rtl/i8080_int_ctrl.sv
// i8080 interrupt controller: synchronised requests, pending/mask registers,
// fixed priority (source 0 highest) and RST opcode supply during acknowledge.
module i8080_int_ctrl
    import soc_pkg::*;
#(
    parameter int         NUM_SRC     = 2,
    parameter int         SYNC_STAGES = 2,
    parameter int         BASE_RST    = 1,
    parameter logic [7:0] LEVEL_MODE  = 8'h00,
    parameter logic [7:0] MASK_RST    = 8'hFF,
    parameter logic [7:0] MASK_PORT   = DEF_MASK_PORT,
    parameter logic [7:0] PEND_PORT   = DEF_PEND_PORT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_inta,
    output logic               o_int,
    output logic [7:0]         o_vector,
    input  logic               i_io_wr,
    input  logic               i_io_rd,
    input  logic [7:0]         i_io_addr,
    input  logic [7:0]         i_io_data,
    output logic [7:0]         o_io_data,
    output logic               o_io_hit
);

    logic [NUM_SRC-1:0] w_level;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] w_pendNext;
    logic [NUM_SRC-1:0] w_enabled;
    logic [NUM_SRC-1:0] w_clear;
    logic [2:0]         w_winIdx;
    logic               w_anyEn;
    logic               w_maskWr;
    logic               w_pendWr;
    logic               w_ackStart;
    logic               w_ackEnd;
    logic               r_int;
    logic [7:0]         r_vector;
    ack_state_t         r_state;
    ack_state_t         w_stateNext;
    logic               w_unused_ioData;

    // Upper write-data bits beyond NUM_SRC are intentionally ignored.
    assign w_unused_ioData = &{1'b0, i_io_data};

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_sync
        int_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_async (i_src[k]),
            .o_level (w_level[k]),
            .o_rise  (w_rise[k])
        );
    end

    assign w_maskWr  = i_io_wr && (i_io_addr == MASK_PORT);
    assign w_pendWr  = i_io_wr && (i_io_addr == PEND_PORT);
    assign w_enabled = r_pend & r_mask;
    assign w_anyEn   = |w_enabled;

    // Fixed priority: scan from the top so the lowest enabled index is left as the winner.
    always_comb begin
        w_winIdx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_enabled[k]) begin
                w_winIdx = 3'(k);
            end
        end
    end

    // Ack handshake state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ACK_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Enter BUSY on the i_inta rising edge, leave when i_inta falls.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ACK_IDLE: if (i_inta)  w_stateNext = ACK_BUSY;
            ACK_BUSY: if (!i_inta) w_stateNext = ACK_IDLE;
            default:               w_stateNext = ACK_IDLE;
        endcase
    end

    // Handshake strobes: first cycle of an acknowledge and the cycle it ends.
    always_comb begin
        w_ackStart = 1'b0;
        w_ackEnd   = 1'b0;
        case (r_state)
            ACK_IDLE: w_ackStart = i_inta;
            ACK_BUSY: w_ackEnd   = ~i_inta;
            default:  w_ackStart = 1'b0;
        endcase
    end

    // Clear requests from the acknowledged winner and PEND_PORT writes; a new edge overrides both.
    always_comb begin
        w_clear    = '0;
        w_pendNext = r_pend;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_ackStart && w_anyEn && (k == int'(w_winIdx))) begin
                w_clear[k] = 1'b1;
            end
            if (w_pendWr && i_io_data[k]) begin
                w_clear[k] = 1'b1;
            end
            if (LEVEL_MODE[k]) begin
                w_pendNext[k] = w_level[k];
            end else begin
                w_pendNext[k] = w_rise[k] | (r_pend[k] & ~w_clear[k]);
            end
        end
    end

    // Pending and mask registers; pending latches regardless of the mask.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_mask <= MASK_RST[NUM_SRC-1:0];
        end else begin
            r_pend <= w_pendNext;
            if (w_maskWr) begin
                r_mask <= i_io_data[NUM_SRC-1:0];
            end
        end
    end

    // Interrupt request lags the pending state by a cycle and is held off during an acknowledge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_int <= 1'b0;
        end else begin
            r_int <= w_anyEn & ~i_inta;
        end
    end

    // Vector is captured at the start of an acknowledge and returns to RST 7 when it ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vector <= SPURIOUS_VEC;
        end else if (w_ackStart) begin
            r_vector <= w_anyEn ? rst_opcode(3'(BASE_RST + int'(w_winIdx))) : SPURIOUS_VEC;
        end else if (w_ackEnd) begin
            r_vector <= SPURIOUS_VEC;
        end
    end

    assign o_int    = r_int;
    assign o_vector = r_vector;
    assign o_io_hit = i_io_rd && ((i_io_addr == MASK_PORT) || (i_io_addr == PEND_PORT));

    // Combinational IO read mux, zero when this block is not addressed.
    always_comb begin
        o_io_data = 8'h00;
        if (i_io_rd) begin
            if (i_io_addr == MASK_PORT) begin
                o_io_data = 8'(r_mask);
            end else if (i_io_addr == PEND_PORT) begin
                o_io_data = 8'(r_pend);
            end
        end
    end

endmodule

// File: tb/tb_i8080_int_ctrl.sv
// Self-checking bench for i8080_int_ctrl: default-parameter instance checked every
// cycle against a sample-history model, plus a 4-source level-mode instance.
module tb_i8080_int_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] src;
    logic       inta;
    logic       ioWr;
    logic       ioRd;
    logic [7:0] ioAddr;
    logic [7:0] ioWData;
    logic       oInt;
    logic [7:0] oVector;
    logic [7:0] oIoData;
    logic       oIoHit;

    logic [3:0] src4;
    logic       inta4;
    logic       oInt4;
    logic [7:0] oVector4;
    logic [7:0] oIoData4;
    logic       oIoHit4;

    int checks = 0;
    int errors = 0;
    bit modelReady = 1'b0;

    logic [1:0] hist[$];
    logic [1:0] mPend;
    logic [1:0] mMask;
    logic       mInt;
    logic [7:0] mVec;
    logic       mBusy;

    i8080_int_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_src(src), .i_inta(inta),
        .o_int(oInt), .o_vector(oVector),
        .i_io_wr(ioWr), .i_io_rd(ioRd), .i_io_addr(ioAddr), .i_io_data(ioWData),
        .o_io_data(oIoData), .o_io_hit(oIoHit)
    );

    i8080_int_ctrl #(
        .NUM_SRC(4), .BASE_RST(4), .LEVEL_MODE(8'h08)
    ) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_src(src4), .i_inta(inta4),
        .o_int(oInt4), .o_vector(oVector4),
        .i_io_wr(ioWr), .i_io_rd(ioRd), .i_io_addr(ioAddr), .i_io_data(ioWData),
        .o_io_data(oIoData4), .o_io_hit(oIoHit4)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] histAt(input int i);
        return (i < hist.size()) ? hist[i] : 2'b00;
    endfunction

    // Model: synchronised level is the raw sample SYNC edges old; the register state follows the rules directly.
    always @(posedge clk or negedge rst_n) begin : model
        logic [1:0] oldPend;
        logic [1:0] oldMask;
        logic [1:0] en;
        logic [1:0] clr;
        logic [1:0] rise;
        int         winner;
        bit         found;
        if (!rst_n) begin
            hist.delete();
            mPend = 2'b00;
            mMask = 2'b11;
            mInt  = 1'b0;
            mVec  = 8'hFF;
            mBusy = 1'b0;
        end else begin
            oldPend = mPend;
            oldMask = mMask;
            en      = oldPend & oldMask;
            rise    = histAt(SYNC - 1) & ~histAt(SYNC);
            clr     = 2'b00;
            found   = 1'b0;
            winner  = 0;
            for (int k = 0; k < 2; k++) begin
                if (en[k] && !found) begin
                    winner = k;
                    found  = 1'b1;
                end
            end
            if (inta && !mBusy) begin
                if (found) begin
                    clr[winner] = 1'b1;
                    mVec = 8'(199 + 8 * (1 + winner));
                end else begin
                    mVec = 8'hFF;
                end
            end else if (mBusy && !inta) begin
                mVec = 8'hFF;
            end
            if (ioWr && ioAddr == 8'h06) clr = clr | ioWData[1:0];
            if (ioWr && ioAddr == 8'h05) mMask = ioWData[1:0];
            mPend = (oldPend & ~clr) | rise;
            mInt  = (en != 2'b00) && !inta;
            mBusy = inta;
            hist.push_front(src);
            if (hist.size() > SYNC + 1) void'(hist.pop_back());
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 8'h%02h expected 8'h%02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare all outputs of the default instance against the model.
    always @(negedge clk) begin
        logic [7:0] expData;
        logic       expHit;
        if (modelReady) begin
            expData = 8'h00;
            expHit  = 1'b0;
            if (ioRd && ioAddr == 8'h05) begin expData = {6'b0, mMask}; expHit = 1'b1; end
            if (ioRd && ioAddr == 8'h06) begin expData = {6'b0, mPend}; expHit = 1'b1; end
            checkOutput("model o_int", {7'b0, oInt}, {7'b0, mInt});
            checkOutput("model o_vector", oVector, mVec);
            checkOutput("model o_io_data", oIoData, expData);
            checkOutput("model o_io_hit", {7'b0, oIoHit}, {7'b0, expHit});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic a);
        src  = s;
        inta = a;
    endtask

    task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data);
        ioWr = 1'b1; ioAddr = addr; ioWData = data;
        tick(1);
        ioWr = 1'b0; ioAddr = 8'h00; ioWData = 8'h00;
    endtask

    task automatic ioRead(input string name, input bit useDut4, input logic [7:0] addr, input logic [7:0] expected);
        ioRd = 1'b1; ioAddr = addr;
        @(negedge clk);
        #1;
        checkOutput(name, useDut4 ? oIoData4 : oIoData, expected);
        ioRd = 1'b0; ioAddr = 8'h00;
        tick(1);
    endtask

    task automatic waitInt(input string name, input bit useDut4, input int budget);
        int n = 0;
        while (((useDut4 ? oInt4 : oInt) !== 1'b1) && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, {7'b0, (useDut4 ? oInt4 : oInt)}, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0;
        src = 2'b00; inta = 1'b0; src4 = 4'b0000; inta4 = 1'b0;
        ioWr = 1'b0; ioRd = 1'b0; ioAddr = 8'h00; ioWData = 8'h00;
        #1 modelReady = 1'b1;
        tick(3);
        checkOutput("reset o_int", {7'b0, oInt}, 8'h00);
        checkOutput("reset o_vector", oVector, 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        ioRead("reset mask", 1'b0, 8'h05, 8'h03);
        ioRead("reset pend", 1'b0, 8'h06, 8'h00);
        ioRead("reset mask dut4", 1'b1, 8'h05, 8'h0F);
        ioRead("unmapped read", 1'b0, 8'h07, 8'h00);

        $display("[TB] test 1: single source ack");
        applyStimulus(2'b01, 1'b0);
        tick(3);
        applyStimulus(2'b00, 1'b0);
        waitInt("t1 o_int rises", 1'b0, 3);
        ioRead("t1 pend", 1'b0, 8'h06, 8'h01);
        applyStimulus(2'b00, 1'b1);
        tick(1);
        checkOutput("t1 vector", oVector, 8'hCF);
        checkOutput("t1 o_int during ack", {7'b0, oInt}, 8'h00);
        ioRead("t1 pend cleared", 1'b0, 8'h06, 8'h00);
        applyStimulus(2'b00, 1'b0);
        tick(2);
        checkOutput("t1 vector idle", oVector, 8'hFF);
        checkOutput("t1 o_int stays low", {7'b0, oInt}, 8'h00);

        $display("[TB] test 2: simultaneous sources");
        applyStimulus(2'b11, 1'b0);
        tick(3);
        applyStimulus(2'b00, 1'b0);
        waitInt("t2 o_int rises", 1'b0, 3);
        applyStimulus(2'b00, 1'b1);
        tick(2);
        checkOutput("t2 first vector", oVector, 8'hCF);
        applyStimulus(2'b00, 1'b0);
        tick(1);
        checkOutput("t2 o_int reasserts", {7'b0, oInt}, 8'h01);
        applyStimulus(2'b00, 1'b1);
        tick(1);
        checkOutput("t2 second vector", oVector, 8'hD7);
        applyStimulus(2'b00, 1'b0);
        tick(2);
        ioRead("t2 pend empty", 1'b0, 8'h06, 8'h00);

        $display("[TB] test 3: mask");
        ioWrite(8'h05, 8'h01);
        applyStimulus(2'b10, 1'b0);
        tick(3);
        applyStimulus(2'b00, 1'b0);
        tick(3);
        checkOutput("t3 masked o_int", {7'b0, oInt}, 8'h00);
        ioRead("t3 pend masked", 1'b0, 8'h06, 8'h02);
        ioRead("t3 mask readback", 1'b0, 8'h05, 8'h01);
        ioWrite(8'h05, 8'hF3);
        waitInt("t3 o_int after unmask", 1'b0, 3);
        applyStimulus(2'b00, 1'b1);
        tick(1);
        checkOutput("t3 vector", oVector, 8'hD7);
        applyStimulus(2'b00, 1'b0);
        tick(2);

        $display("[TB] test 4: spurious ack and set-wins");
        applyStimulus(2'b00, 1'b1);
        tick(1);
        checkOutput("t4 spurious vector", oVector, 8'hFF);
        applyStimulus(2'b00, 1'b0);
        tick(1);
        ioRead("t4 pend unchanged", 1'b0, 8'h06, 8'h00);
        applyStimulus(2'b01, 1'b0);
        tick(3);
        applyStimulus(2'b00, 1'b0);
        waitInt("t4 o_int rises", 1'b0, 4);
        tick(4);
        applyStimulus(2'b01, 1'b0);
        tick(2);
        applyStimulus(2'b01, 1'b1);
        tick(1);
        checkOutput("t4 collision vector", oVector, 8'hCF);
        applyStimulus(2'b00, 1'b1);
        ioRead("t4 pend kept by new edge", 1'b0, 8'h06, 8'h01);
        applyStimulus(2'b00, 1'b0);
        tick(1);
        checkOutput("t4 o_int after ack", {7'b0, oInt}, 8'h01);
        ioWrite(8'h06, 8'hFF);
        tick(2);
        ioRead("t4 pend cleared by write", 1'b0, 8'h06, 8'h00);
        checkOutput("t4 o_int dropped", {7'b0, oInt}, 8'h00);

        $display("[TB] test 6: reset during ack");
        ioWrite(8'h05, 8'h01);
        applyStimulus(2'b11, 1'b0);
        tick(3);
        applyStimulus(2'b00, 1'b0);
        waitInt("t6 o_int rises", 1'b0, 4);
        ioRead("t6 pend both", 1'b0, 8'h06, 8'h03);
        applyStimulus(2'b00, 1'b1);
        tick(1);
        checkOutput("t6 vector before reset", oVector, 8'hCF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6 o_int async reset", {7'b0, oInt}, 8'h00);
        checkOutput("t6 vector async reset", oVector, 8'hFF);
        ioRd = 1'b1; ioAddr = 8'h05;
        #1 checkOutput("t6 mask async reset", oIoData, 8'h03);
        ioAddr = 8'h06;
        #1 checkOutput("t6 pend async reset", oIoData, 8'h00);
        ioRd = 1'b0; ioAddr = 8'h00;
        applyStimulus(2'b00, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick(2);

        $display("[TB] test 5: level source on 4-source instance");
        src4 = 4'b1000;
        waitInt("t5 o_int rises", 1'b1, 5);
        ioRead("t5 pend level", 1'b1, 8'h06, 8'h08);
        inta4 = 1'b1;
        tick(1);
        checkOutput("t5 vector rst7", oVector4, 8'hFF);
        checkOutput("t5 o_int during ack", {7'b0, oInt4}, 8'h00);
        inta4 = 1'b0;
        tick(1);
        checkOutput("t5 o_int reasserts", {7'b0, oInt4}, 8'h01);
        ioRead("t5 pend not cleared", 1'b1, 8'h06, 8'h08);
        src4 = 4'b0000;
        tick(5);
        ioRead("t5 pend follows level", 1'b1, 8'h06, 8'h00);
        checkOutput("t5 o_int drops", {7'b0, oInt4}, 8'h00);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
